// File: rtl/serdes_lane_arbiter.sv
// Two-requester round-robin arbiter feeding a single serial TX lane.
// Each frame is start, id, data (LSB first), even parity over id+data, stop.
module serdes_lane_arbiter #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  output logic              ser_out_o,
  output logic              busy_o,
  output logic              grant_id_o,
  output logic              frame_done_o
);

  localparam int unsigned BaudW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned MaxBits = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int unsigned CntW    = (MaxBits > 1) ? $clog2(MaxBits) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StId, StData, StParity, StStop} state_e;

  state_e              state_q, state_d;
  logic [BaudW-1:0]    baud_q, baud_d;
  logic [CntW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                par_q, par_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic                ser_q, ser_d;
  logic                busy_q, busy_d;

  logic idle, pick1, accept, baud_last;
  logic [DATA_W-1:0] win_data;

  // last_q holds the id granted most recently; reset value 1 makes req0 win first.
  assign idle         = (state_q == StIdle);
  assign pick1        = (req0_valid_i & req1_valid_i) ? ~last_q : req1_valid_i;
  assign req0_ready_o = rst_ni & idle & req0_valid_i & ~pick1;
  assign req1_ready_o = rst_ni & idle & req1_valid_i & pick1;
  assign accept       = req0_ready_o | req1_ready_o;
  assign win_data     = pick1 ? req1_data_i : req0_data_i;

  assign baud_last    = (baud_q == BaudW'(CLKS_PER_BIT - 1));
  assign frame_done_o = (state_q == StStop) & baud_last & (bit_q == CntW'(STOP_BITS - 1));

  assign ser_out_o    = ser_q;
  assign busy_o       = busy_q;
  assign grant_id_o   = grant_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    grant_d = grant_q;
    last_d  = last_q;

    if (idle) begin
      if (accept) begin
        state_d = StStart;
        baud_d  = '0;
        bit_d   = '0;
        shreg_d = win_data;
        par_d   = pick1 ^ (^win_data);
        grant_d = pick1;
        last_d  = pick1;
      end
    end else if (!baud_last) begin
      baud_d = baud_q + BaudW'(1);
    end else begin
      baud_d = '0;
      unique case (state_q)
        StStart: state_d = StId;
        StId: begin
          state_d = StData;
          bit_d   = '0;
        end
        StData: begin
          shreg_d = shreg_q >> 1;
          if (bit_q == CntW'(DATA_W - 1)) begin
            state_d = StParity;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + CntW'(1);
          end
        end
        StParity: begin
          state_d = StStop;
          bit_d   = '0;
        end
        StStop: begin
          if (bit_q == CntW'(STOP_BITS - 1)) begin
            state_d = StIdle;
          end else begin
            bit_d = bit_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Lane level is decoded from the next state so ser_out is a clean register output.
  always_comb begin
    ser_d  = 1'b1;
    busy_d = (state_d != StIdle);
    unique case (state_d)
      StIdle:   ser_d = 1'b1;
      StStart:  ser_d = 1'b0;
      StId:     ser_d = grant_d;
      StData:   ser_d = shreg_d[0];
      StParity: ser_d = par_d;
      StStop:   ser_d = 1'b1;
      default:  ser_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_serdes_lane_arbiter.sv
// Randomized bench for serdes_lane_arbiter against a frame-level reference model,
// plus a CLKS_PER_BIT=1 instance for the single-cycle-bit case.
module tb_serdes_lane_arbiter;

  localparam int DW   = 8;
  localparam int CPB  = 4;
  localparam int SB   = 1;
  localparam int NB   = 3 + DW + SB;
  localparam int N    = NB * CPB;
  localparam int N1   = NB;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          v0, v1, r0, r1, ser, busy, gid, done;
  logic [DW-1:0] d0, d1;
  logic          w0, w1, q0, q1, ser1, busy1, gid1, done1;
  logic [DW-1:0] wd0, wd1;

  serdes_lane_arbiter #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(r0),
    .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(r1),
    .ser_out_o(ser), .busy_o(busy), .grant_id_o(gid), .frame_done_o(done)
  );

  serdes_lane_arbiter #(.DATA_W(DW), .CLKS_PER_BIT(1), .STOP_BITS(SB)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(w0), .req0_data_i(wd0), .req0_ready_o(q0),
    .req1_valid_i(w1), .req1_data_i(wd1), .req1_ready_o(q1),
    .ser_out_o(ser1), .busy_o(busy1), .grant_id_o(gid1), .frame_done_o(done1)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame as an ordered bit list: index 0 is the start bit.
  function automatic logic [NB-1:0] frame_bits(input logic id, input logic [DW-1:0] data);
    logic [NB-1:0] b;
    b    = '1;
    b[0] = 1'b0;
    b[1] = id;
    for (int i = 0; i < DW; i++) b[2+i] = data[i];
    b[2+DW] = id ^ (^data);
    return b;
  endfunction

  // Reference model: pos = cycle within the frame (0 = idle, 1..N on the lane).
  int            pos;
  logic          cur_id, last_id, acc0, acc1;
  logic [NB-1:0] fbits;

  task automatic model_reset();
    pos = 0; last_id = 1'b1; acc0 = 1'b0; acc1 = 1'b0;
  endtask

  task automatic step();
    logic e0, e1;
    e0 = 1'b0; e1 = 1'b0;
    if (pos == 0) begin
      if (v0 && v1) begin
        e0 = last_id; e1 = ~last_id;
      end else begin
        e0 = v0; e1 = v1;
      end
    end
    check_eq("ser_out", ser, (pos == 0) ? 1 : fbits[(pos-1)/CPB]);
    check_eq("busy", busy, pos != 0);
    check_eq("frame_done", done, pos == N);
    if (pos != 0) check_eq("grant_id", gid, cur_id);
    check_eq("ready0", r0, e0);
    check_eq("ready1", r1, e1);
    check_eq("one_ready", r0 & r1, 0);
    acc0 = e0; acc1 = e1;
    if (e0 || e1) begin
      cur_id  = e1;
      last_id = e1;
      fbits   = frame_bits(e1, e1 ? d1 : d0);
      pos     = 1;
    end else if (pos != 0) begin
      pos = (pos == N) ? 0 : pos + 1;
    end
  endtask

  task automatic rand_inputs();
    if (acc0 || !v0) begin
      v0 = ($urandom_range(0, 3) != 0); d0 = DW'($urandom);
    end else if ($urandom_range(0, 15) == 0) v0 = 1'b0;
    if (acc1 || !v1) begin
      v1 = ($urandom_range(0, 3) != 0); d1 = DW'($urandom);
    end else if ($urandom_range(0, 15) == 0) v1 = 1'b0;
  endtask

  initial begin
    int last_acc, n_acc;
    logic hit;
    logic [NB-1:0] b1;

    rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
    w0 = 1'b0; w1 = 1'b0; wd0 = '0; wd1 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ser", ser, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready0", r0, 0);
    check_eq("rst_ready1", r1, 0);
    check_eq("rst_done", done, 0);

    // Single req0 frame 0xA5, then single req1 frame 0x03.
    @(negedge clk); v0 = 1'b0; v1 = 1'b0; rst_n = 1'b1;
    @(negedge clk); v0 = 1'b1; d0 = 8'hA5; #1; step();
    repeat (N + 2) begin @(negedge clk); v0 = 1'b0; #1; step(); end
    @(negedge clk); v1 = 1'b1; d1 = 8'h03; #1; step();
    repeat (N + 2) begin @(negedge clk); v1 = 1'b0; #1; step(); end

    // Fairness: both valid continuously; accepts must be N+1 apart.
    n_acc = 0; last_acc = 0;
    for (int c = 0; c < 3 * (N + 1) + 2; c++) begin
      @(negedge clk); v0 = 1'b1; v1 = 1'b1; d0 = 8'h01; d1 = 8'h80; #1;
      if (r0 | r1) begin
        if (n_acc > 0) check_eq("fair_spacing", c - last_acc, N + 1);
        check_eq("fair_grant", r1, n_acc % 2);
        last_acc = c; n_acc++;
      end
      step();
    end
    check_eq("fair_accepts", n_acc, 4);

    // Random traffic.
    v0 = 1'b0; v1 = 1'b0;
    repeat (1500) begin @(negedge clk); rand_inputs(); #1; step(); end

    // Reset while data bit 3 is on the lane (frame bit index 5).
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge clk); v0 = 1'b1; v1 = 1'b1; #1; step();
      hit = (pos != 0) && ((pos - 1) / CPB == 5);
    end
    check_eq("reach_data_bit3", hit, 1);
    @(negedge clk); rst_n = 1'b0; #1;
    check_eq("midrst_ser", ser, 1);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_ready0", r0, 0);
    check_eq("midrst_ready1", r1, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 8'h3C; d1 = 8'hC3; #1;
    check_eq("midrst_req0_wins", r0, 1);
    step();
    repeat (1500) begin @(negedge clk); rand_inputs(); #1; step(); end

    // Single-cycle bits: 0xA5 from req0 on the CLKS_PER_BIT=1 instance.
    @(negedge clk); v0 = 1'b0; v1 = 1'b0; w0 = 1'b1; wd0 = 8'hA5; #1;
    check_eq("cpb1_ready0", q0, 1);
    b1 = frame_bits(1'b0, 8'hA5);
    for (int k = 1; k <= N1 + 1; k++) begin
      @(negedge clk); w0 = 1'b0; #1;
      check_eq("cpb1_ser", ser1, (k <= N1) ? b1[k-1] : 1);
      check_eq("cpb1_busy", busy1, k <= N1);
      check_eq("cpb1_done", done1, k == N1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
